sja_bus_responder: RTL

- Target end of the SJA1000-style Intel-mode multiplexed bus (AD[7:0], ALE, CS_N, RD_N, WR_N).
- Emulates a CAN-controller register window inside the FPGA so the OPB-side initiator bridge can be exercised in ATE loopback without silicon.
- Bus strobes are asynchronous and are oversampled in the OPB_CLK domain.
- Contents: register file, interrupt register with enable mask, active-low interrupt pin, and a local port that lets firmware-side logic preload registers and raise interrupt flags.

---
 rtl/sja_bus_pkg.sv | 19 +
 rtl/sja_bus_sync.sv | 33 +++
 rtl/sja_bus_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sja_bus_pkg.sv
// sja_bus_pkg: shared types and register map for the SJA1000-style bus responder.
// Holds FSM states, special register addresses and IR bit positions.
package sja_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALE_HI  = 3'd1,
    ST_ADDR_OK = 3'd2,
    ST_RD_ACT  = 3'd3,
    ST_WR_ACT  = 3'd4
  } state_t;

  localparam logic [7:0] IR_ADDR  = 8'h03;
  localparam logic [7:0] IER_ADDR = 8'h04;

  localparam int PROTO_ERR = 7;
  localparam int TIMEOUT   = 6;

endpackage

// File: rtl/sja_bus_sync.sv
// sja_bus_sync: multi-flop synchronizer for one asynchronous bus strobe
// with rise/fall pulses taken from the synchronized level.
module sja_bus_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
      r_prev <= r_chain[STAGES-1];
    end
  end

  assign o_q    = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/sja_bus_responder.sv
// sja_bus_responder: SJA1000 Intel-mode bus target emulating a CAN register window.
// Optional access watchdog is enabled by defining SJA_BUS_TIMEOUT_EN.
module sja_bus_responder
  import sja_bus_pkg::*;
#(
  parameter int  REG_DEPTH   = 32,
  parameter int  SYNC_STAGES = 2,
  parameter int  TIMEOUT_CYC = 255,
  localparam int AW          = $clog2(REG_DEPTH)
) (
  input  logic          OPB_CLK,
  input  logic          OPB_RST,
  inout  wire  [7:0]    BUS_AD,
  input  logic          BUS_ALE,
  input  logic          BUS_CS_N,
  input  logic          BUS_RD_N,
  input  logic          BUS_WR_N,
  output logic          BUS_INT_N,
  output logic          BUS_DIR,
  input  logic [AW-1:0] LCL_ADDR,
  input  logic [7:0]    LCL_DI,
  input  logic          LCL_WE,
  output logic [7:0]    LCL_DO,
  input  logic [7:0]    LCL_IRQ_SET,
  output logic          WR_EVT,
  output logic [7:0]    WR_ADDR,
  output logic [7:0]    WR_DATA,
  output logic          LCL_COLL
);

  state_t        r_state, w_st_nxt;
  logic [7:0]    r_ad [SYNC_STAGES];
  logic [7:0]    r_regs [REG_DEPTH];
  logic [7:0]    r_addr, r_wdata, r_rdata, r_ir;
  logic [7:0]    r_wr_addr, r_wr_data;
  logic          r_int_n, r_wr_evt, r_coll;

  logic          w_ale_s, w_ale_rise, w_ale_fall;
  logic          w_cs_s, w_cs_rise, w_cs_fall;
  logic          w_rd_s, w_rd_rise, w_rd_fall;
  logic          w_wr_s, w_wr_rise, w_wr_fall;
  logic [7:0]    w_ad_s, w_bus_rd, w_ir_nxt, w_ier;
  logic [AW-1:0] w_bidx;
  logic          w_in_rng, w_bus_ir, w_lcl_ir;
  logic          w_rd_go, w_rd_end, w_commit, w_commit_ok;
  logic          w_abort, w_proto, w_tmo, w_coll;
  logic          w_rd_done, w_wr_done;
  logic [3:0]    w_unused;

  sja_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ale (
    .i_clk(OPB_CLK), .i_rst(OPB_RST), .i_d(BUS_ALE),
    .o_q(w_ale_s), .o_rise(w_ale_rise), .o_fall(w_ale_fall));

  sja_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_clk(OPB_CLK), .i_rst(OPB_RST), .i_d(BUS_CS_N),
    .o_q(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  sja_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rd (
    .i_clk(OPB_CLK), .i_rst(OPB_RST), .i_d(BUS_RD_N),
    .o_q(w_rd_s), .o_rise(w_rd_rise), .o_fall(w_rd_fall));

  sja_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wr (
    .i_clk(OPB_CLK), .i_rst(OPB_RST), .i_d(BUS_WR_N),
    .o_q(w_wr_s), .o_rise(w_wr_rise), .o_fall(w_wr_fall));

  assign w_unused = {w_ale_s, w_cs_fall, w_rd_fall, w_wr_fall};

  // AD is delayed exactly like the strobes so edges and data line up
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_ad[i] <= '0;
    end else begin
      r_ad[0] <= BUS_AD;
      for (int i = 1; i < SYNC_STAGES; i++) r_ad[i] <= r_ad[i-1];
    end
  end

  assign w_ad_s = r_ad[SYNC_STAGES-1];

`ifdef SJA_BUS_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                       $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [7:0] IR_MASK = 8'hFF;

  logic [WDW-1:0] r_wdog;
  logic           w_act;

  assign w_act = (r_state == ST_RD_ACT) || (r_state == ST_WR_ACT);
  assign w_tmo = w_act && (r_wdog == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) r_wdog <= '0;
    else         r_wdog <= (w_act && !w_tmo) ? r_wdog + WDW'(1) : '0;
  end
`else
  localparam logic [7:0] IR_MASK    = 8'hBF;
  localparam int         unused_tmo = TIMEOUT_CYC;

  assign w_tmo = 1'b0;
`endif

  assign w_rd_done = w_rd_rise | w_cs_rise;
  assign w_wr_done = w_wr_rise | w_cs_rise;

  always_comb begin
    w_st_nxt = r_state;
    w_rd_go  = 1'b0;
    w_rd_end = 1'b0;
    w_commit = 1'b0;
    w_abort  = 1'b0;
    w_proto  = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_ale_rise) w_st_nxt = ST_ALE_HI;
      ST_ALE_HI: if (w_ale_fall) w_st_nxt = ST_ADDR_OK;
      ST_ADDR_OK: begin
        if (w_ale_rise) begin
          w_st_nxt = ST_ALE_HI;
        end else if (!w_cs_s && !w_rd_s && !w_wr_s) begin
          w_proto = 1'b1;
        end else if (!w_cs_s && !w_rd_s) begin
          w_st_nxt = ST_RD_ACT;
          w_rd_go  = 1'b1;
        end else if (!w_cs_s && !w_wr_s) begin
          w_st_nxt = ST_WR_ACT;
        end
      end
      ST_RD_ACT: begin
        if (w_ale_rise) begin
          w_st_nxt = ST_ALE_HI;
          w_abort  = 1'b1;
        end else if (w_tmo) begin
          w_st_nxt = ST_IDLE;
        end else if (w_rd_done) begin
          w_st_nxt = ST_ADDR_OK;
          w_rd_end = 1'b1;
        end
      end
      ST_WR_ACT: begin
        if (w_ale_rise) begin
          w_st_nxt = ST_ALE_HI;
          w_abort  = 1'b1;
        end else if (w_tmo) begin
          w_st_nxt = ST_IDLE;
        end else if (w_wr_done) begin
          w_st_nxt = ST_ADDR_OK;
          w_commit = 1'b1;
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  assign w_in_rng    = 32'(r_addr) < REG_DEPTH;
  assign w_bidx      = r_addr[AW-1:0];
  assign w_bus_ir    = (r_addr == IR_ADDR);
  assign w_lcl_ir    = (LCL_ADDR == IR_ADDR[AW-1:0]);
  assign w_ier       = r_regs[IER_ADDR[AW-1:0]];
  assign w_commit_ok = w_commit && w_in_rng;
  assign w_coll      = LCL_WE && w_commit_ok && (w_bidx == LCL_ADDR);

  always_comb begin
    w_bus_rd = r_regs[w_bidx];
    unique case (1'b1)
      !w_in_rng: w_bus_rd = '0;
      w_bus_ir:  w_bus_rd = r_ir;
      default:   ;
    endcase
  end

  // Bus wins over local, sets win over every clear
  always_comb begin
    w_ir_nxt = r_ir;
    if (LCL_WE && w_lcl_ir && !w_coll) w_ir_nxt = LCL_DI;
    if (w_commit_ok && w_bus_ir) w_ir_nxt = w_ir_nxt & ~r_wdata;
    if (w_rd_end && w_bus_ir) w_ir_nxt = '0;
    w_ir_nxt = w_ir_nxt | LCL_IRQ_SET;
    if (w_proto || w_abort) w_ir_nxt[PROTO_ERR] = 1'b1;
    if (w_tmo) w_ir_nxt[TIMEOUT] = 1'b1;
    w_ir_nxt = w_ir_nxt & IR_MASK;
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (LCL_WE && !w_lcl_ir) r_regs[LCL_ADDR] <= LCL_DI;
      if (w_commit_ok && !w_bus_ir) r_regs[w_bidx] <= r_wdata;
    end
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_ir      <= '0;
      r_int_n   <= 1'b1;
      r_wr_evt  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_coll    <= 1'b0;
    end else begin
      r_state  <= w_st_nxt;
      r_ir     <= w_ir_nxt;
      r_int_n  <= ~|(r_ir & w_ier);
      r_wr_evt <= w_commit;
      r_coll   <= w_coll;
      if (r_state == ST_ALE_HI && w_ale_fall) r_addr <= w_ad_s;
      if (r_state == ST_WR_ACT && !w_wr_done) r_wdata <= w_ad_s;
      if (w_rd_go) r_rdata <= w_bus_rd;
      if (w_commit) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_wdata;
      end
    end
  end

  assign BUS_DIR   = (r_state == ST_RD_ACT);
  assign BUS_AD    = BUS_DIR ? r_rdata : 'z;
  assign BUS_INT_N = r_int_n;
  assign LCL_DO    = w_lcl_ir ? r_ir : r_regs[LCL_ADDR];
  assign WR_EVT    = r_wr_evt;
  assign WR_ADDR   = r_wr_addr;
  assign WR_DATA   = r_wr_data;
  assign LCL_COLL  = r_coll;

endmodule
